fir_param: RTL and testbench

- Parametrised direct-form FIR filter; next generation of the fixed 11-tap, 9-bit myfir.
- Tap count, data width and coefficient width are generic.
- Coefficients are held in internal registers loaded by a strobe, instead of being wired live.
- Output is rescaled and saturated; same VIN/VOUT sample-valid framing, sits between data source and data sink.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_sat.sv | 30 +++
 rtl/fir_param.sv | 138 +++++++++++++
 tb/tb_fir_param.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and sizing helpers for the FIR family
package fir_pkg;

  localparam int DEF_N_TAPS = 11;
  localparam int DEF_DW     = 9;
  localparam int DEF_CW     = 9;

  // ceil(log2(v)) for v >= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // accumulator wide enough that summing n full-precision products never overflows
  function automatic int accw(input int dw, input int cw, input int n);
    return dw + cw + clog2(n);
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/fir_sat.sv
// rtl/fir_sat.sv - arithmetic shift by CW-1 then saturate ACCW down to DW
module fir_sat
  import fir_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int CW   = DEF_CW,
  parameter int ACCW = accw(DEF_DW, DEF_CW, DEF_N_TAPS)
) (
  input  logic signed [ACCW-1:0] acc_i,
  output logic signed [DW-1:0]   dout_o
);

  localparam logic signed [ACCW-1:0] MAX_V = ACCW'(sat_max(DW));
  localparam logic signed [ACCW-1:0] MIN_V = ACCW'(sat_min(DW));

  logic signed [ACCW-1:0] scaled;

  // drop the Q1.(CW-1) fraction (floor) and clamp to the output range
  always_comb begin
    scaled = acc_i >>> (CW - 1);
    if (scaled > MAX_V) begin
      dout_o = MAX_V[DW-1:0];
    end else if (scaled < MIN_V) begin
      dout_o = MIN_V[DW-1:0];
    end else begin
      dout_o = scaled[DW-1:0];
    end
  end

endmodule

// File: rtl/fir_param.sv
// rtl/fir_param.sv - parametrised direct-form FIR with strobe-loaded coefficients
// Optional build macro FIR_PIPE_EN: registers all products, latency 2 instead of 1.
module fir_param
  import fir_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int DW     = DEF_DW,
  parameter int CW     = DEF_CW
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 VIN,
  input  logic [DW-1:0]        DIN,
  input  logic                 COEF_LD,
  input  logic [N_TAPS*CW-1:0] B,
  output logic                 VOUT,
  output logic [DW-1:0]        DOUT
);

  localparam int ACCW = accw(DW, CW, N_TAPS);
  localparam int PW   = DW + CW;

  logic signed [CW-1:0]   coef_q [N_TAPS];
  logic signed [CW-1:0]   coef_d [N_TAPS];
  logic signed [DW-1:0]   dly_q  [N_TAPS-1];
  logic signed [DW-1:0]   dly_d  [N_TAPS-1];
  logic signed [DW-1:0]   taps   [N_TAPS];
  logic signed [PW-1:0]   prod_d [N_TAPS];
  logic signed [PW-1:0]   mac_in [N_TAPS];
  logic                   mac_v;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   sat_y;
  logic                   vout_q, vout_d;
  logic [DW-1:0]          dout_q, dout_d;

  // coefficient bank loads on strobe; delay line only advances on valid samples
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      coef_d[k] = COEF_LD ? $signed(B[k*CW +: CW]) : coef_q[k];
    end
    for (int k = 0; k < N_TAPS - 1; k++) begin
      dly_d[k] = dly_q[k];
    end
    if (VIN) begin
      dly_d[0] = $signed(DIN);
      for (int k = 1; k < N_TAPS - 1; k++) begin
        dly_d[k] = dly_q[k-1];
      end
    end
  end

  // full-precision products of current sample and history with current coefficients
  always_comb begin
    taps[0] = $signed(DIN);
    for (int k = 1; k < N_TAPS; k++) begin
      taps[k] = dly_q[k-1];
    end
    for (int k = 0; k < N_TAPS; k++) begin
      prod_d[k] = $signed({{CW{taps[k][DW-1]}}, taps[k]}) *
                  $signed({{DW{coef_q[k][CW-1]}}, coef_q[k]});
    end
  end

`ifdef FIR_PIPE_EN
  logic signed [PW-1:0] prod_q [N_TAPS];
  logic                 prod_v_q, prod_v_d;

  // product stage valid simply follows VIN
  always_comb begin
    prod_v_d = VIN;
    for (int k = 0; k < N_TAPS; k++) begin
      mac_in[k] = prod_q[k];
    end
    mac_v = prod_v_q;
  end

  // product stage advances every cycle so a later coefficient load cannot touch it
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
      prod_v_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_TAPS; k++) prod_q[k] <= prod_d[k];
      prod_v_q <= prod_v_d;
    end
  end
`else
  // products feed the accumulator directly
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      mac_in[k] = prod_d[k];
    end
    mac_v = VIN;
  end
`endif

  // sign-extended sum; ACCW leaves headroom for every product at full scale
  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      acc = acc + {{(ACCW-PW){mac_in[k][PW-1]}}, mac_in[k]};
    end
  end

  fir_sat #(
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_sat (
    .acc_i  (acc),
    .dout_o (sat_y)
  );

  // output register holds its value across gaps
  always_comb begin
    vout_d = mac_v;
    dout_d = mac_v ? sat_y : dout_q;
  end

  // state registers; reset clears history, coefficients and outputs
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int k = 0; k < N_TAPS; k++)     coef_q[k] <= '0;
      for (int k = 0; k < N_TAPS - 1; k++) dly_q[k]  <= '0;
      vout_q <= 1'b0;
      dout_q <= '0;
    end else begin
      for (int k = 0; k < N_TAPS; k++)     coef_q[k] <= coef_d[k];
      for (int k = 0; k < N_TAPS - 1; k++) dly_q[k]  <= dly_d[k];
      vout_q <= vout_d;
      dout_q <= dout_d;
    end
  end

  assign VOUT = vout_q;
  assign DOUT = dout_q;

endmodule

// File: tb/tb_fir_param.sv
// tb/tb_fir_param.sv - self-checking bench for fir_param against an integer reference model
module tb_fir_param;

  localparam int N_TAPS = 11;
  localparam int DW     = 9;
  localparam int CW     = 9;
`ifdef FIR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 CLK;
  logic                 RST_n;
  logic                 VIN;
  logic [DW-1:0]        DIN;
  logic                 COEF_LD;
  logic [N_TAPS*CW-1:0] B;
  logic                 VOUT;
  logic [DW-1:0]        DOUT;

  fir_param #(.N_TAPS(N_TAPS), .DW(DW), .CW(CW)) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .VIN     (VIN),
    .DIN     (DIN),
    .COEF_LD (COEF_LD),
    .B       (B),
    .VOUT    (VOUT),
    .DOUT    (DOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int failures = 0;

  // stimulus coefficients (what is on B) and model state
  int cb    [N_TAPS];
  int mcoef [N_TAPS];
  int hist  [N_TAPS];
  int m_dout;
  bit m_vout;
  bit m_pv;
  int m_pval;
  int outs [$];

  // y = floor(sum(b_k * x[n-k]) / 2^(CW-1)), clamped to the DW-bit signed range
  function automatic int model_y(input int din);
    longint sum;
    longint d;
    longint s;
    longint hi;
    longint lo;
    d   = longint'(1) << (CW - 1);
    hi  = (longint'(1) << (DW - 1)) - 1;
    lo  = -(longint'(1) << (DW - 1));
    sum = longint'(mcoef[0]) * din;
    for (int k = 1; k < N_TAPS; k++) sum += longint'(mcoef[k]) * hist[k];
    if (sum >= 0) s = sum / d;
    else          s = -((-sum + d - 1) / d);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return int'(s);
  endfunction

  task automatic cyc(input bit rst_n, input bit vin, input int din, input bit ld);
    int y;
    logic [DW-1:0] exp_d;
    RST_n   = rst_n;
    VIN     = vin;
    DIN     = din[DW-1:0];
    COEF_LD = ld;
    for (int k = 0; k < N_TAPS; k++) B[k*CW +: CW] = cb[k][CW-1:0];
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        mcoef[k] = 0;
        hist[k]  = 0;
      end
      m_vout = 1'b0;
      m_dout = 0;
      m_pv   = 1'b0;
      m_pval = 0;
    end else begin
      y = model_y(din);
      if (LAT == 2) begin
        m_vout = m_pv;
        if (m_pv) m_dout = m_pval;
        m_pv   = vin;
        m_pval = y;
      end else begin
        m_vout = vin;
        if (vin) m_dout = y;
      end
      if (vin) begin
        for (int k = N_TAPS - 1; k >= 2; k--) hist[k] = hist[k-1];
        hist[1] = din;
      end
      if (ld) begin
        for (int k = 0; k < N_TAPS; k++) mcoef[k] = cb[k];
      end
    end
    @(posedge CLK);
    #1;
    exp_d = m_dout[DW-1:0];
    checks++;
    assert (VOUT === m_vout) else begin
      failures++;
      $error("FAIL vout t=%0t observed=%b expected=%b", $time, VOUT, m_vout);
    end
    checks++;
    assert (DOUT === exp_d) else begin
      failures++;
      $error("FAIL dout t=%0t observed=%0d expected=%0d", $time, $signed(DOUT), $signed(exp_d));
    end
    if (VOUT === 1'b1) outs.push_back(int'($signed(DOUT)));
  endtask

  // impulse -256 through bk=k+1 gives -1..-11 then 0
  task automatic check_impulse(input string tag);
    int e;
    checks++;
    assert (outs.size() == N_TAPS + 1) else begin
      failures++;
      $error("FAIL %s_count observed=%0d expected=%0d", tag, outs.size(), N_TAPS + 1);
    end
    for (int i = 0; i < outs.size() && i <= N_TAPS; i++) begin
      e = (i < N_TAPS) ? -(i + 1) : 0;
      checks++;
      assert (outs[i] === e) else begin
        failures++;
        $error("FAIL %s_out%0d observed=%0d expected=%0d", tag, i, outs[i], e);
      end
    end
  endtask

  task automatic set_ramp_coefs();
    for (int k = 0; k < N_TAPS; k++) cb[k] = k + 1;
  endtask

  task automatic flush();
    for (int i = 0; i < LAT + 1; i++) cyc(1, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < N_TAPS; k++) cb[k] = 0;

    // reset state
    cyc(0, 0, 0, 0);
    cyc(0, 1, 100, 1);

    // 1: impulse response with ramp coefficients
    set_ramp_coefs();
    cyc(1, 0, 0, 1);
    outs.delete();
    cyc(1, 1, -256, 0);
    for (int i = 0; i < N_TAPS; i++) cyc(1, 1, 0, 0);
    flush();
    check_impulse("impulse");

    // 2: saturation in both directions
    cyc(0, 0, 0, 0);
    for (int k = 0; k < N_TAPS; k++) cb[k] = 255;
    cyc(1, 0, 0, 1);
    for (int i = 0; i < N_TAPS; i++) cyc(1, 1, 255, 0);
    for (int i = 0; i < N_TAPS; i++) cyc(1, 1, -256, 0);
    flush();
    checks++;
    assert (outs.size() > 0 && outs[outs.size()-1] === -256) else begin
      failures++;
      $error("FAIL sat_neg observed=%0d expected=%0d", (outs.size() > 0) ? outs[outs.size()-1] : 999, -256);
    end

    // 3: same impulse with VIN gaps
    cyc(0, 0, 0, 0);
    set_ramp_coefs();
    cyc(1, 0, 0, 1);
    outs.delete();
    for (int i = 0; i <= N_TAPS; i++) begin
      cyc(1, 1, (i == 0) ? -256 : 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
    end
    flush();
    check_impulse("gapped");

    // 4: load in the same cycle as a sample
    cyc(0, 0, 0, 0);
    for (int k = 0; k < N_TAPS; k++) cb[k] = 128;
    outs.delete();
    cyc(1, 1, -256, 1);
    cyc(1, 1, 0, 0);
    flush();
    checks++;
    assert (outs.size() == 2 && outs[0] === 0 && outs[1] === -128) else begin
      failures++;
      $error("FAIL same_cycle_load observed=%0d,%0d expected=0,-128",
             (outs.size() > 0) ? outs[0] : 999, (outs.size() > 1) ? outs[1] : 999);
    end

    // 5: reset mid-stream
    set_ramp_coefs();
    cyc(1, 0, 0, 1);
    cyc(1, 1, -256, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, $urandom_range(0, 511) - 256, 0);
    flush();

    // 6: random coefficients, continuous random samples
    cyc(0, 0, 0, 0);
    for (int k = 0; k < N_TAPS; k++) cb[k] = $urandom_range(0, 511) - 256;
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 50; i++) cyc(1, 1, $urandom_range(0, 511) - 256, 0);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
